// File: rtl/i2s_tx_engine.sv
// i2s_tx_engine: I2S / left-justified stereo serialiser with double-buffered samples
module i2s_tx_engine #(
  parameter int DATA_W    = 16,
  parameter int SLOT_W    = 16,
  parameter int BCK_DIV   = 2,
  parameter int FMT_I2S   = 0,
  parameter int HOLD_LAST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  input  logic              mute,
  output logic              audio_appsel,
  output logic              audio_sysclk,
  output logic              audio_bck,
  output logic              audio_ws,
  output logic              audio_data,
  output logic              underrun,
  output logic              frame_start
);
  localparam int BW = $clog2(2 * SLOT_W);
  localparam int DW = BCK_DIV > 1 ? $clog2(BCK_DIV) : 1;
  localparam logic [BW-1:0] LAST = BW'(2 * SLOT_W - 1);
  localparam logic [BW-1:0] SW = BW'(SLOT_W);
  localparam logic [DW-1:0] DLAST = DW'(BCK_DIV - 1);
  localparam logic [DATA_W-1:0] MSB = DATA_W'(1) << (DATA_W - 1);
  logic [DW-1:0]     r_div;
  logic [BW-1:0]     r_bit;
  logic              r_bck, r_ws, r_data, r_full, r_mute, r_ur, r_fs;
  logic [DATA_W-1:0] r_hold_l, r_hold_r, r_sh_l, r_sh_r;
  logic              w_tick, w_fall, w_bnd, w_load, w_acc, w_old, w_dch, w_src_m, w_data;
  logic [BW-1:0]     w_nbit, w_didx, w_dk;
  logic [DATA_W-1:0] w_nsh_l, w_nsh_r, w_src_l, w_src_r, w_word;
  assign w_tick  = r_div == DLAST;
  assign w_fall  = w_tick & r_bck;
  assign w_bnd   = w_fall & (r_bit == LAST);
  assign w_load  = w_bnd & r_full;
  assign s_ready = !r_full | w_load;
  assign w_acc   = s_valid & s_ready;
  assign w_nbit  = (r_bit == LAST) ? '0 : r_bit + 1'b1;
  assign w_didx  = (FMT_I2S != 0) ? ((w_nbit == '0) ? LAST : w_nbit - 1'b1) : w_nbit;
  assign w_dch   = w_didx >= SW;
  assign w_dk    = w_dch ? w_didx - SW : w_didx;
  assign w_nsh_l = w_load ? r_hold_l : ((HOLD_LAST != 0) ? r_sh_l : '0);
  assign w_nsh_r = w_load ? r_hold_r : ((HOLD_LAST != 0) ? r_sh_r : '0);
  // In I2S the boundary edge still emits the outgoing frame's last right bit
  assign w_old   = (FMT_I2S != 0) & w_bnd;
  assign w_src_l = (w_bnd & !w_old) ? w_nsh_l : r_sh_l;
  assign w_src_r = (w_bnd & !w_old) ? w_nsh_r : r_sh_r;
  assign w_src_m = (w_bnd & !w_old) ? mute : r_mute;
  assign w_word  = w_dch ? w_src_r : w_src_l;
  assign w_data  = !w_src_m & |((w_word << w_dk) & MSB);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div    <= '0;
      r_bit    <= '0;
      r_bck    <= 1'b0;
      r_ws     <= 1'b0;
      r_data   <= 1'b0;
      r_full   <= 1'b0;
      r_mute   <= 1'b0;
      r_ur     <= 1'b0;
      r_fs     <= 1'b0;
      r_hold_l <= '0;
      r_hold_r <= '0;
      r_sh_l   <= '0;
      r_sh_r   <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      r_fs  <= w_bnd;
      r_ur  <= w_bnd & !r_full;
      if (w_tick) r_bck <= !r_bck;
      if (w_fall) begin
        r_bit  <= w_nbit;
        r_ws   <= w_nbit >= SW;
        r_data <= w_data;
      end
      if (w_bnd) begin
        r_sh_l <= w_nsh_l;
        r_sh_r <= w_nsh_r;
        r_mute <= mute;
      end
      if (w_acc) begin
        r_hold_l <= s_left;
        r_hold_r <= s_right;
        r_full   <= 1'b1;
      end else if (w_load) r_full <= 1'b0;
    end
  end
  assign audio_appsel = 1'b1;
  assign audio_sysclk = clk;
  assign audio_bck    = r_bck;
  assign audio_ws     = r_ws;
  assign audio_data   = r_data;
  assign underrun     = r_ur;
  assign frame_start  = r_fs;
endmodule

// File: tb/tb_i2s_tx_engine.sv
// tb_i2s_tx_engine: LJ/HOLD_LAST=1 and I2S/HOLD_LAST=0 instances against a frame-level model
module tb_i2s_tx_engine;
  localparam int D = 2, S = 16, FP = 4 * S * D;
  logic clk = 1'b0, rst = 1'b1, s_valid = 1'b0, mute = 1'b0;
  logic [15:0] s_left = '0, s_right = '0;
  logic a_ready, a_appsel, a_sysclk, a_bck, a_ws, a_data, a_ur, a_fs;
  logic b_ready, b_appsel, b_sysclk, b_bck, b_ws, b_data, b_ur, b_fs;
  always #5 clk = ~clk;
  i2s_tx_engine #(.DATA_W(16), .SLOT_W(S), .BCK_DIV(D), .FMT_I2S(0), .HOLD_LAST(1)) u_a (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(a_ready), .s_left(s_left),
    .s_right(s_right), .mute(mute), .audio_appsel(a_appsel), .audio_sysclk(a_sysclk),
    .audio_bck(a_bck), .audio_ws(a_ws), .audio_data(a_data), .underrun(a_ur),
    .frame_start(a_fs));
  i2s_tx_engine #(.DATA_W(16), .SLOT_W(S), .BCK_DIV(D), .FMT_I2S(1), .HOLD_LAST(0)) u_b (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(b_ready), .s_left(s_left),
    .s_right(s_right), .mute(mute), .audio_appsel(b_appsel), .audio_sysclk(b_sysclk),
    .audio_bck(b_bck), .audio_ws(b_ws), .audio_data(b_data), .underrun(b_ur),
    .frame_start(b_fs));
  typedef struct {
    bit          push;
    int          qf;
    logic [15:0] l, r;
    bit          m;
    logic [15:0] el, er;
    bit          eur;
  } vec_t;
  vec_t tbl[1:7];
  int checks = 0, errors = 0, n = 0;
  bit rnd = 0, hfull = 0, pbck = 0;
  logic [15:0] hl, hr;
  logic [15:0] v1l[0:63], v1r[0:63], v0l[0:63], v0r[0:63], capl[0:63], capr[0:63];
  bit fm[0:63], fur[0:63], urs[0:63];
  logic [15:0] ql[$], qr[$];
  logic [31:0] cap;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s n=%0d got %0h expected %0h", nm, n, act, want);
    end
  endtask
  task automatic chk_reset();
    chk("rst_bck_a", a_bck, 0);   chk("rst_bck_b", b_bck, 0);
    chk("rst_ws_a", a_ws, 0);     chk("rst_ws_b", b_ws, 0);
    chk("rst_data_a", a_data, 0); chk("rst_data_b", b_data, 0);
    chk("rst_ur_a", a_ur, 0);     chk("rst_fs_a", a_fs, 0);
    chk("rst_ur_b", b_ur, 0);     chk("rst_fs_b", b_fs, 0);
    chk("rst_ready_a", a_ready, 1); chk("rst_ready_b", b_ready, 1);
    chk("appsel", a_appsel & b_appsel, 1);
  endtask
  task automatic init_model();
    hfull = 0; pbck = 0; cap = '0; mute = 1'b0; s_valid = 1'b0;
    ql.delete(); qr.delete();
    for (int i = 0; i < 64; i++) begin
      v1l[i] = '0; v1r[i] = '0; v0l[i] = '0; v0r[i] = '0;
      capl[i] = '0; capr[i] = '0; fm[i] = 0; fur[i] = 0; urs[i] = 0;
    end
  endtask
  task automatic check_state();
    int m, b, f, d, bd, fd;
    bit ea, eb, efs;
    m = n / (2 * D); b = m % (2 * S); f = m / (2 * S);
    ea = fm[f] ? 1'b0 : (b >= S ? v1r[f][15 - (b - S)] : v1l[f][15 - b]);
    if (m == 0) eb = 0;
    else begin
      d = m - 1; fd = d / (2 * S); bd = d % (2 * S);
      eb = fm[fd] ? 1'b0 : (bd >= S ? v0r[fd][15 - (bd - S)] : v0l[fd][15 - bd]);
    end
    efs = n > 0 && n % FP == 0;
    chk("bck_a", a_bck, (n / D) % 2); chk("bck_b", b_bck, (n / D) % 2);
    chk("ws_a", a_ws, b >= S);        chk("ws_b", b_ws, b >= S);
    chk("data_lj", a_data, ea);       chk("data_i2s", b_data, eb);
    chk("fs_a", a_fs, efs);           chk("fs_b", b_fs, efs);
    chk("ur_a", a_ur, efs && fur[n / FP]); chk("ur_b", b_ur, efs && fur[n / FP]);
    chk("ready_a", a_ready, !hfull || (n + 1) % FP == 0);
    chk("ready_b", b_ready, !hfull || (n + 1) % FP == 0);
    if (!rnd && (n == 1 || n == 2)) chk("first_rise", a_bck, n == 2);
    if (!rnd && n == 258) begin chk("i2s_tail_ws", b_ws, 0); chk("i2s_tail_bit", b_data, 1); end
    if (!rnd && n == 322) begin chk("i2s_lead_ws", b_ws, 1); chk("i2s_lead_lsb", b_data, 0); chk("lj_r_msb", a_data, 1); end
    if (!rnd && n == 326) chk("i2s_r_msb", b_data, 1);
  endtask
  task automatic capture();
    if (a_bck && !pbck) cap = {cap[30:0], a_data};
    pbck = a_bck;
    if (a_fs && n / FP < 64) begin
      capl[n / FP - 1] = cap[31:16];
      capr[n / FP - 1] = cap[15:0];
      urs[n / FP] = a_ur;
    end
  endtask
  task automatic drive();
    if (!rnd) begin
      if (n % FP == 0)
        for (int e = 1; e <= 7; e++)
          if (tbl[e].push && tbl[e].qf == n / FP) begin ql.push_back(tbl[e].l); qr.push_back(tbl[e].r); end
      if (n % FP == 20 && n / FP + 1 <= 7) mute = tbl[n / FP + 1].m;
    end else begin
      if (ql.size() == 0 && $urandom_range(0, 99) < 2) begin
        ql.push_back(16'($urandom)); qr.push_back(16'($urandom));
      end
      if ($urandom_range(0, 299) == 0) mute = ~mute;
    end
    s_valid = ql.size() > 0;
    if (ql.size() > 0) begin s_left = ql[0]; s_right = qr[0]; end
  endtask
  task automatic model_step();
    bit bnd, acc;
    int f;
    bnd = (n + 1) % FP == 0;
    acc = s_valid && (!hfull || bnd);
    if (bnd) begin
      f = (n + 1) / FP;
      fm[f] = mute; fur[f] = !hfull;
      if (hfull) begin v1l[f] = hl; v1r[f] = hr; v0l[f] = hl; v0r[f] = hr; end
      else begin v1l[f] = v1l[f-1]; v1r[f] = v1r[f-1]; v0l[f] = '0; v0r[f] = '0; end
    end
    if (acc) begin hl = ql.pop_front(); hr = qr.pop_front(); hfull = 1; end
    else if (bnd) hfull = 0;
  endtask
  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      check_state();
      capture();
      drive();
      model_step();
      @(negedge clk);
      n++;
    end
  endtask
  initial begin
    tbl[1] = '{1, 0, 16'hA5F0, 16'h0F0F, 0, 16'hA5F0, 16'h0F0F, 0};
    tbl[2] = '{1, 0, 16'h1234, 16'h8001, 0, 16'h1234, 16'h8001, 0};
    tbl[3] = '{0, 0, 16'h0000, 16'h0000, 0, 16'h1234, 16'h8001, 1};
    tbl[4] = '{1, 3, 16'hBEEF, 16'hCAFE, 1, 16'h0000, 16'h0000, 0};
    tbl[5] = '{1, 4, 16'h7FFF, 16'hFFFF, 0, 16'h7FFF, 16'hFFFF, 0};
    tbl[6] = '{0, 0, 16'h0000, 16'h0000, 0, 16'h7FFF, 16'hFFFF, 1};
    tbl[7] = '{1, 6, 16'h0001, 16'h8000, 0, 16'h0001, 16'h8000, 0};
    init_model();
    repeat (5) begin @(negedge clk); chk_reset(); end
    rst = 1'b0; n = 0;
    run(8 * FP + 11);
    chk("frame0_l", capl[0], 0); chk("frame0_r", capr[0], 0);
    for (int f = 1; f <= 7; f++) begin
      chk($sformatf("frame%0d_l", f), capl[f], tbl[f].el);
      chk($sformatf("frame%0d_r", f), capr[f], tbl[f].er);
      chk($sformatf("frame%0d_ur", f), urs[f], tbl[f].eur);
    end
    chk("pre_rst_bck", a_bck, 1);
    #2 rst = 1'b1;
    #1 chk_reset();
    repeat (4) begin @(negedge clk); chk_reset(); end
    init_model();
    rst = 1'b0; n = 0; rnd = 1;
    run(12 * FP);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
